// File: rtl/physics_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : physics_pkg                                                   |
// | Brief    : Shared types and helpers for the player vertical physics.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package physics_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RIDE = 2'd1,
    ST_AIR  = 2'd2
  } state_t;

  typedef logic signed [7:0]  vel_t;
  typedef logic signed [10:0] pos_t;

  localparam logic [1:0] c_FRAME_STILL = 2'd0;
  localparam logic [1:0] c_FRAME_RISE  = 2'd1;
  localparam logic [1:0] c_FRAME_FALL  = 2'd2;

  // One guard bit keeps a sum near either rail from wrapping before the clamp.
  function automatic logic [9:0] clamp_pos(input pos_t a, input pos_t b, input pos_t floor_pos);
    logic signed [11:0] sum;
    sum = $signed({a[10], a}) + $signed({b[10], b});
    if (sum < $signed({floor_pos[10], floor_pos}))
      clamp_pos = floor_pos[9:0];
    else if (sum > 12'sd1023)
      clamp_pos = 10'd1023;
    else
      clamp_pos = sum[9:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/player_physics_edge_rise.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : edge_rise                                                     |
// | Brief    : Registered one-cycle pulse on a rising edge of a level input. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module edge_rise (
  input  logic clock,
  input  logic reset_n,
  input  logic level,
  output logic pulse
);

  logic r_sync;
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= level;
      r_prev  <= r_sync;
      r_pulse <= r_sync & ~r_prev;
    end
  end

  assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/player_physics.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : player_physics                                                |
// | Brief    : Per-frame surfer vertical motion (ride / jump / gravity).     |
// |            Define WAVE_LAUNCH_EN to let steep wave rises launch player.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module player_physics #(
  parameter int CHAR_HEIGHT   = 20,
  parameter int REST_VPOS     = 300,
  parameter int TOP_LIMIT     = 40,
  parameter int GRAVITY       = 1,
  parameter int JUMP_VEL      = 12,
  parameter int MAX_FALL      = 15,
  parameter int MAX_STEP      = 4,
  parameter int LAUNCH_THRESH = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic [9:0] wave_height,
  input  logic       wave_ready,
  input  logic       jump,
  input  logic       playing,
  output logic [9:0] p_vpos,
  output logic [1:0] char_frame,
  output logic       airborne
);
  import physics_pkg::*;

  localparam pos_t       c_TOP      = pos_t'(TOP_LIMIT);
  localparam pos_t       c_JUMP     = pos_t'(JUMP_VEL);
  localparam pos_t       c_GRAV     = pos_t'(GRAVITY);
  localparam pos_t       c_MAX_FALL = pos_t'(MAX_FALL);
  localparam pos_t       c_MAX_STEP = pos_t'(MAX_STEP);
  localparam pos_t       c_LAUNCH   = pos_t'(LAUNCH_THRESH);
  localparam logic [9:0] c_REST     = 10'(REST_VPOS);
  localparam logic [9:0] c_CHAR     = 10'(CHAR_HEIGHT);
  localparam logic [9:0] c_TOP10    = 10'(TOP_LIMIT);
`ifdef WAVE_LAUNCH_EN
  localparam logic       c_LAUNCH_EN = 1'b1;
`else
  localparam logic       c_LAUNCH_EN = 1'b0;
`endif

  logic       w_tick;
  logic       w_jump_edge;
  state_t     r_state, w_state_nxt;
  vel_t       r_vel, w_vel_nxt;
  logic [9:0] r_pos, w_pos_nxt;
  logic [1:0] r_frame, w_frame_nxt;
  logic [9:0] r_surface;
  logic       r_jump_pend;

  edge_rise u_vsync_edge (.clock(clock), .reset_n(reset_n), .level(vsync), .pulse(w_tick));
  edge_rise u_jump_edge  (.clock(clock), .reset_n(reset_n), .level(jump),  .pulse(w_jump_edge));

  // A jump edge landing on a tick survives that tick's clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_surface   <= c_REST;
      r_jump_pend <= 1'b0;
    end else begin
      if (wave_ready)
        r_surface <= (wave_height < c_CHAR + c_TOP10) ? c_TOP10 : wave_height - c_CHAR;
      if (w_jump_edge)
        r_jump_pend <= 1'b1;
      else if (w_tick)
        r_jump_pend <= 1'b0;
    end
  end

  pos_t               w_p, w_s, w_rise, w_drop, w_half, w_vel_air;
  logic signed [11:0] w_n;
  logic               w_launch;
  vel_t               w_launch_vel;

  assign w_p          = pos_t'({1'b0, r_pos});
  assign w_s          = pos_t'({1'b0, r_surface});
  assign w_rise       = w_p - w_s;
  assign w_drop       = w_s - w_p;
  assign w_half       = w_rise >>> 1;
  assign w_launch     = c_LAUNCH_EN && (w_rise > c_LAUNCH);
  assign w_launch_vel = (w_half > 11'sd127) ? -8'sd127 : -vel_t'(w_half);
  assign w_vel_air    = (pos_t'(r_vel) + c_GRAV > c_MAX_FALL) ? c_MAX_FALL : pos_t'(r_vel) + c_GRAV;
  assign w_n          = $signed({w_p[10], w_p}) + $signed({w_vel_air[10], w_vel_air});

  always_comb begin
    w_state_nxt = r_state;
    w_vel_nxt   = r_vel;
    w_pos_nxt   = r_pos;
    if (!playing) begin
      w_state_nxt = ST_IDLE;
      w_vel_nxt   = '0;
      w_pos_nxt   = c_REST;
    end else if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_RIDE;
          w_vel_nxt   = '0;
          w_pos_nxt   = r_surface;
        end
        ST_RIDE: begin
          if (r_jump_pend) begin
            w_state_nxt = ST_AIR;
            w_vel_nxt   = -vel_t'(c_JUMP);
            w_pos_nxt   = clamp_pos(w_p, -c_JUMP, c_TOP);
          end else if (w_rise > 0) begin
            w_pos_nxt = r_surface;
            if (w_launch) begin
              w_state_nxt = ST_AIR;
              w_vel_nxt   = w_launch_vel;
            end
          end else if (w_drop > c_MAX_STEP) begin
            w_state_nxt = ST_AIR;
            w_vel_nxt   = '0;
          end else begin
            w_pos_nxt = r_surface;
          end
        end
        ST_AIR: begin
          if ((w_vel_air > 0) && (w_n >= $signed({w_s[10], w_s}))) begin
            w_state_nxt = ST_RIDE;
            w_vel_nxt   = '0;
            w_pos_nxt   = r_surface;
          end else begin
            w_pos_nxt = clamp_pos(w_p, w_vel_air, c_TOP);
            w_vel_nxt = (w_n < $signed({c_TOP[10], c_TOP})) ? '0 : vel_t'(w_vel_air);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_vel_nxt   = '0;
          w_pos_nxt   = c_REST;
        end
      endcase
    end
    w_frame_nxt = (w_state_nxt != ST_AIR) ? c_FRAME_STILL :
                  (w_vel_nxt < 0)         ? c_FRAME_RISE  : c_FRAME_FALL;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_vel   <= '0;
      r_pos   <= c_REST;
      r_frame <= c_FRAME_STILL;
    end else begin
      r_state <= w_state_nxt;
      r_vel   <= w_vel_nxt;
      r_pos   <= w_pos_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  assign p_vpos     = r_pos;
  assign char_frame = r_frame;
  assign airborne   = (r_state == ST_AIR);

endmodule
`default_nettype wire

// File: doc/player_physics.md
# player_physics

Per-frame vertical motion for the surfer character: tracks the wave surface supplied by the waveform stage, integrates jumps and gravity, and produces the player vertical position and animation frame consumed by `game_logic` (`p_vpos`, `char_frame`). Updates once per VGA frame on the rising edge of `vsync`. Sits between the waveform/height generator and `game_logic`.

## Interface
- `CHAR_HEIGHT`, 20: character sprite height in pixels.
- `REST_VPOS`, 300: `p_vpos` when not playing.
- `TOP_LIMIT`, 40: smallest legal `p_vpos` (ceiling).
- `GRAVITY`, 1: velocity increment per frame while airborne.
- `JUMP_VEL`, 12: upward speed applied by a jump.
- `MAX_FALL`, 15: downward velocity saturation.
- `MAX_STEP`, 4: largest surface drop followed while riding.
- `LAUNCH_THRESH`, 6: surface rise that launches the player (only with `WAVE_LAUNCH_EN`).

Ports:
- `clock` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `vsync` in 1: VGA vsync level.
- `wave_height` in 10: wave surface row under the player; smaller values are higher on screen.
- `wave_ready` in 1: `wave_height` valid this cycle.
- `jump` in 1: jump button level, already debounced.
- `playing` in 1: high while `game_logic` is in PLAY.
- `p_vpos` out 10: player top row.
- `char_frame` out 2: 0 stationary, 1 rising, 2 falling.
- `airborne` out 1: high in AIR.

## Operation
- The surface register holds `max(wave_height - CHAR_HEIGHT, TOP_LIMIT)`. It is loaded on every `wave_ready`. If `wave_height < CHAR_HEIGHT`, the register takes `TOP_LIMIT`.
- Jump request: a rising edge of `jump` sets `jump_pend`. `jump_pend` is cleared on every tick.
- Velocity `vel` is signed 8-bit; positive means downward. All position arithmetic is 11-bit signed and clamped to `[TOP_LIMIT, 1023]`.
- Frame tick: a one-cycle pulse generated from the rising edge of `vsync`. Every state update below happens on a tick.
- States: IDLE, RIDE, AIR.
- IDLE:
  - `p_vpos=REST_VPOS`, `vel=0`.
  - On a tick with `playing=1`: go to RIDE, set `p_vpos=surface`. No launch check is made on this tick.
- RIDE, with priority in this order:
  1. If `jump_pend`: go to AIR, `vel=-JUMP_VEL`, `p_vpos=p_vpos-JUMP_VEL`.
  2. If the surface is above `p_vpos` (rise `r>0`): set `p_vpos=surface`. With `WAVE_LAUNCH_EN` and `r>LAUNCH_THRESH`, also go to AIR with `vel=-(r>>1)`.
  3. If the surface drops by `d`, where `0<d≤MAX_STEP`: set `p_vpos=surface`.
  4. If `d>MAX_STEP`: go to AIR, `vel=0`, `p_vpos` unchanged.
- AIR:
  - `vel'=min(vel+GRAVITY, MAX_FALL)`, `n=p_vpos+vel'`.
  - If `vel'>0` and `n≥surface`: `p_vpos=surface`, `vel=0`, go to RIDE.
  - Else if `n<TOP_LIMIT`: `p_vpos=TOP_LIMIT`, `vel=0`.
  - Otherwise `p_vpos=n`.
  - A pending jump is discarded.
- `char_frame`: 0 in IDLE and RIDE; in AIR, 1 if `vel<0`, otherwise 2. Registered and updated together with `p_vpos`.
- `playing` low: go to IDLE on the next cycle, tick not required. Outputs reach their IDLE values on that same edge.

## Timing
- Reset values: `p_vpos=REST_VPOS`, `char_frame=0`, `airborne=0`, `vel=0`, surface `=REST_VPOS`, state IDLE, `jump_pend=0`.
- Latency from a `vsync` rising edge:
  - Tick is asserted in the cycle after `vsync` is first sampled high.
  - Outputs update on the edge that ends the tick cycle, i.e. 2 cycles after `vsync` is sampled high.
- Exactly one update per `vsync` rise. `vsync` held high produces no further ticks.
- `wave_ready` coincident with a tick: the tick uses the previously held surface; the new sample takes effect at the next tick.
- `jump` rising edge coincident with a tick: the edge is held for the next tick.
- `reset_n` asserted mid-frame: all state returns to reset values immediately.

## Configuration
- `WAVE_LAUNCH_EN` defined: RIDE performs the launch check, so a surface rise greater than `LAUNCH_THRESH` throws the player into AIR.
- `WAVE_LAUNCH_EN` undefined: surface rises always snap `p_vpos` and the block stays in RIDE. `LAUNCH_THRESH` is unused.

## Structure
- Package `physics_pkg`: state enum (IDLE/RIDE/AIR), `vel_t` (signed 8-bit), `pos_t` (signed 11-bit), `char_frame` encodings.
- Sub-module `edge_rise`: one-cycle rising-edge detector with async active-low reset. Instantiated twice, once for `vsync` and once for `jump`.

## Test plan
1. Reset, then `playing=1`, `wave_height=300`, one `vsync` pulse -> RIDE, `p_vpos=280`, `char_frame=0`, 2 cycles after `vsync` is sampled high.
2. In RIDE at 280, pulse `jump`, then ticks -> `p_vpos` = 268, 257, 247, …; reaches 202 with `char_frame` 2 at tick 13; lands at 280 on tick 25 with `char_frame=0` and `airborne=0`.
3. In RIDE at 280, `wave_height` goes 300→303 -> `p_vpos=283` in RIDE; then 303→313 -> AIR, `vel=0`, `p_vpos=283`, `char_frame=2`.
4. In RIDE at 280, `wave_height` goes 300→290 -> with `WAVE_LAUNCH_EN`: AIR, `p_vpos=270`, `vel=-5`, `char_frame=1`; without it: RIDE, `p_vpos=270`, `char_frame=0`.
5. `wave_height=30` in AIR rising -> clamps at `TOP_LIMIT=40` with `vel=0`; `jump` pressed while airborne -> ignored.
6. `playing` drops mid-air -> next cycle `p_vpos=300`, `char_frame=0`, `airborne=0`; `reset_n` low mid-frame -> same values immediately.
